inst_boot_loader: RTL

//  Sits upstream of mycpu_top and replaces bench-driven instruction preload.

---
 rtl/inst_boot_loader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/inst_boot_loader.sv
// inst_boot_loader: receives a framed byte stream (LEN_LO, LEN_HI, N*4 data bytes, CSUM),
// packs little-endian 32-bit words and writes them to inst_sram at consecutive word
// addresses starting at BASE_ADDR. The core stays in reset until the checksum matches.
//
// Ports:
//   i_clk                clock
//   i_reset              asynchronous active-low reset
//   i_start              one-cycle pulse, begins a new load from IDLE/DONE/ERR
//   i_rx_data/i_rx_valid byte stream input; a byte moves when valid & ready
//   o_rx_ready           loader accepts a byte this cycle
//   o_inst_sram_wen      one-cycle write strobe
//   o_inst_sram_waddr    64-bit word address of the write
//   o_inst_sram_wdata    32-bit instruction word
//   o_inst_sram_en_toif  enables instruction fetch once the image is good
//   o_core_reset         active-high reset to the core
//   o_boot_done          image loaded and checksum ok (level)
//   o_boot_err           checksum or length error (level)
//   o_words_loaded       words written in the current load
module inst_boot_loader #(
  parameter logic [63:0] BASE_ADDR = 64'd1,
  parameter logic [15:0] MAX_WORDS = 16'd1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_inst_sram_wen,
  output logic [63:0] o_inst_sram_waddr,
  output logic [31:0] o_inst_sram_wdata,
  output logic        o_inst_sram_en_toif,
  output logic        o_core_reset,
  output logic        o_boot_done,
  output logic        o_boot_err,
  output logic [15:0] o_words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t      r_state;
  logic        r_rx_ready;
  logic        r_wen;
  logic [63:0] r_waddr;
  logic [31:0] r_wdata;
  logic        r_en_toif;
  logic        r_core_reset;
  logic        r_done;
  logic        r_err;
  logic [15:0] r_words;
  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic [7:0]  r_csum;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_shift;

  logic        w_accept;
  logic [15:0] w_len;
  logic [31:0] w_word;
  logic [15:0] w_words_nxt;

  assign w_accept    = i_rx_valid & r_rx_ready;
  assign w_len       = {i_rx_data, r_len_lo};
  // The incoming byte completes the word as its most significant byte.
  assign w_word      = {i_rx_data, r_shift};
  assign w_words_nxt = r_words + 16'd1;

  // Loader FSM with all outputs registered on the transition edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_rx_ready   <= 1'b0;
      r_wen        <= 1'b0;
      r_waddr      <= BASE_ADDR;
      r_wdata      <= 32'd0;
      r_en_toif    <= 1'b0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_words      <= 16'd0;
      r_len_lo     <= 8'd0;
      r_len        <= 16'd0;
      r_csum       <= 8'd0;
      r_byte_idx   <= 2'd0;
      r_shift      <= 24'd0;
    end else begin
      r_wen <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_state      <= S_LEN_LO;
            r_rx_ready   <= 1'b1;
            r_words      <= 16'd0;
            r_csum       <= 8'd0;
            r_byte_idx   <= 2'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_reset <= 1'b1;
            r_en_toif    <= 1'b0;
            r_waddr      <= BASE_ADDR;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len_lo <= i_rx_data;
            r_state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len <= w_len;
            if (w_len > MAX_WORDS) begin
              r_state      <= S_ERR;
              r_rx_ready   <= 1'b0;
              r_err        <= 1'b1;
              r_core_reset <= 1'b1;
              r_en_toif    <= 1'b0;
            end else if (w_len == 16'd0) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_csum     <= r_csum + i_rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_shift[7:0]   <= i_rx_data;
              2'd1: r_shift[15:8]  <= i_rx_data;
              2'd2: r_shift[23:16] <= i_rx_data;
              default: begin
                // Fourth byte: issue the write; the count advances with the strobe.
                r_wen   <= 1'b1;
                r_waddr <= BASE_ADDR + 64'(r_words);
                r_wdata <= w_word;
                r_words <= w_words_nxt;
                if (w_words_nxt == r_len) begin
                  r_state <= S_CSUM;
                end
              end
            endcase
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            r_rx_ready <= 1'b0;
            if (i_rx_data == r_csum) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_core_reset <= 1'b0;
              r_en_toif    <= 1'b1;
            end else begin
              r_state      <= S_ERR;
              r_err        <= 1'b1;
              r_core_reset <= 1'b1;
              r_en_toif    <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_rx_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_ready          = r_rx_ready;
  assign o_inst_sram_wen     = r_wen;
  assign o_inst_sram_waddr   = r_waddr;
  assign o_inst_sram_wdata   = r_wdata;
  assign o_inst_sram_en_toif = r_en_toif;
  assign o_core_reset        = r_core_reset;
  assign o_boot_done         = r_done;
  assign o_boot_err          = r_err;
  assign o_words_loaded      = r_words;

endmodule
